// File: rtl/hood_run_scheduler_if.sv
// Hood scheduler boundary: mode requests and power level in, run state and display values out.
// The menu side drives the master modport and the scheduler sits on the slave modport.
interface hood_run_scheduler_if;
  logic       power_on;
  logic       req_valid;
  logic [2:0] req_mode;
  logic [2:0] run_state;
  logic [1:0] fan_level;
  logic [7:0] secs_left;
  logic       hurricane_used;
  logic       clean_done;
  logic       busy;

  modport master (
    output power_on, req_valid, req_mode,
    input  run_state, fan_level, secs_left, hurricane_used, clean_done, busy
  );

  modport slave (
    input  power_on, req_valid, req_mode,
    output run_state, fan_level, secs_left, hurricane_used, clean_done, busy
  );
endinterface

// File: rtl/hood_run_scheduler.sv
// Kitchen-hood fan run scheduler: standby, L1, L2, one-shot hurricane, exit delay and self-clean.
// All outputs come straight from registers; run_state doubles as the FSM debug view.
module hood_run_scheduler #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int HURR_SEC      = 60,
  parameter int EXIT_SEC      = 60,
  parameter int CLEAN_SEC     = 180
) (
  input logic            clk,
  input logic            rst,
  hood_run_scheduler_if.slave hood
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_L1      = 3'd2,
    S_L2      = 3'd3,
    S_HURR    = 3'd4,
    S_EXIT    = 3'd5,
    S_CLEAN   = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [7:0]    secs, secs_next;
  logic          hurr_used, hurr_used_next;
  logic          clean_pulse, clean_pulse_next;
  logic [1:0]    fan, fan_next;
  logic          busy_q, busy_next;
  logic          sec_tick;
  logic          expiry;

  // req_valid is a one-cycle strobe with no ready: the scheduler always takes it on the
  // edge it is sampled, and a request that is not legal in the current state is dropped.

  assign sec_tick = (presc == PRESC_TOP);
  assign expiry   = sec_tick && (secs == 8'd1);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OFF;
      presc       <= '0;
      secs        <= '0;
      hurr_used   <= 1'b0;
      clean_pulse <= 1'b0;
      fan         <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      secs        <= secs_next;
      hurr_used   <= hurr_used_next;
      clean_pulse <= clean_pulse_next;
      fan         <= fan_next;
      busy_q      <= busy_next;
    end
  end

  // Next-state logic, including countdown and entry loads.
  always_comb begin
    state_next       = state;
    secs_next        = secs;
    hurr_used_next   = hurr_used;
    clean_pulse_next = 1'b0;

    if (!hood.power_on) begin
      state_next = S_OFF;
    end else begin
      case (state)
        S_OFF: state_next = S_STANDBY;
        S_STANDBY: begin
          if (hood.req_valid) begin
            case (hood.req_mode)
              3'b001:  state_next = S_L1;
              3'b010:  state_next = S_L2;
              3'b011:  if (!hurr_used) state_next = S_HURR;
              3'b100:  state_next = S_CLEAN;
              default: state_next = S_STANDBY;
            endcase
          end
        end
        S_L1, S_L2: begin
          if (hood.req_valid) begin
            case (hood.req_mode)
              3'b000:  state_next = S_STANDBY;
              3'b001:  state_next = S_L1;
              3'b010:  state_next = S_L2;
              3'b011:  if (!hurr_used) state_next = S_HURR;
              default: state_next = state;
            endcase
          end
        end
        S_HURR: begin
          // Expiry outranks a simultaneous standby request.
          if (expiry) begin
            state_next = S_L2;
          end else begin
            if (sec_tick) secs_next = secs - 8'd1;
            if (hood.req_valid && hood.req_mode == 3'b000) state_next = S_EXIT;
          end
        end
        S_EXIT: begin
          if (expiry)        state_next = S_STANDBY;
          else if (sec_tick) secs_next  = secs - 8'd1;
        end
        S_CLEAN: begin
          if (expiry) begin
            state_next       = S_STANDBY;
            clean_pulse_next = 1'b1;
          end else if (sec_tick) begin
            secs_next = secs - 8'd1;
          end
        end
        default: state_next = S_OFF;
      endcase
    end

    // Any state change reloads the countdown for the state being entered.
    if (state_next != state) begin
      case (state_next)
        S_HURR: begin
          secs_next      = 8'(HURR_SEC);
          hurr_used_next = 1'b1;
        end
        S_EXIT:  secs_next = 8'(EXIT_SEC);
        S_CLEAN: secs_next = 8'(CLEAN_SEC);
        default: secs_next = 8'd0;
      endcase
    end

    if (state_next == S_OFF) hurr_used_next = 1'b0;

    if (state_next != state || sec_tick) presc_next = '0;
    else                                 presc_next = presc + 1'b1;
  end

  // Output decode of the upcoming state, registered alongside it.
  always_comb begin
    fan_next  = 2'd0;
    busy_next = 1'b0;
    case (state_next)
      S_L1:    fan_next = 2'd1;
      S_L2:    fan_next = 2'd2;
      S_HURR:  begin fan_next = 2'd3; busy_next = 1'b1; end
      S_EXIT:  begin fan_next = 2'd3; busy_next = 1'b1; end
      S_CLEAN: busy_next = 1'b1;
      default: fan_next = 2'd0;
    endcase
  end

  assign hood.run_state      = state;
  assign hood.fan_level      = fan;
  assign hood.secs_left      = secs;
  assign hood.hurricane_used = hurr_used;
  assign hood.clean_done     = clean_pulse;
  assign hood.busy           = busy_q;

endmodule

// File: tb/tb_hood_run_scheduler.sv
// Directed bench for hood_run_scheduler with short timing (4 ticks/s, 3/2/5 s runs).
// Observed value packs {run_state, fan_level, secs_left, hurricane_used, clean_done, busy}.
module tb_hood_run_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hood_run_scheduler_if hif();

  hood_run_scheduler #(
    .TICKS_PER_SEC(4),
    .HURR_SEC(3),
    .EXIT_SEC(2),
    .CLEAN_SEC(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hood(hif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {hif.run_state, hif.fan_level, hif.secs_left,
            hif.hurricane_used, hif.clean_done, hif.busy};
  endfunction

  // Advance n edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [2:0] mode);
    hif.req_valid = 1'b1;
    hif.req_mode  = mode;
    tick(1);
    hif.req_valid = 1'b0;
    hif.req_mode  = 3'b000;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst = 1'b1;
    hif.power_on = 1'b0;
    tick(2);
    rst = 1'b0;
    e = {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL reset got=%h want=%h", obs(), e); end
    hif.power_on = 1'b1;
    tick(1);
    e = {3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL power_up got=%h want=%h", obs(), e); end
    req(3'b010);
    e = {3'd3, 2'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL standby_to_l2 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_hurricane_once();
    logic [15:0] e;
    req(3'b001);
    e = {3'd2, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL l2_to_l1 got=%h want=%h", obs(), e); end
    req(3'b011);
    e = {3'd4, 2'd3, 8'd3, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_entry got=%h want=%h", obs(), e); end
    tick(3);
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_e3 got=%h want=%h", obs(), e); end
    tick(1);
    e = {3'd4, 2'd3, 8'd2, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_e4 got=%h want=%h", obs(), e); end
    tick(4);
    e = {3'd4, 2'd3, 8'd1, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_e8 got=%h want=%h", obs(), e); end
    tick(3);
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_e11 got=%h want=%h", obs(), e); end
    tick(1);
    e = {3'd3, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_expire got=%h want=%h", obs(), e); end
    req(3'b011);
    total++; if (obs() !== e) begin bad++; $display("FAIL hurr_second got=%h want=%h", obs(), e); end
  endtask

  task automatic test_early_exit();
    logic [15:0] e;
    logic [7:0]  es;
    hif.power_on = 1'b0;
    tick(1);
    e = {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL power_off got=%h want=%h", obs(), e); end
    hif.power_on = 1'b1;
    tick(1);
    req(3'b011);
    e = {3'd4, 2'd3, 8'd3, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL rehurr got=%h want=%h", obs(), e); end
    tick(4);
    req(3'b000);
    e = {3'd5, 2'd3, 8'd2, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL exit_entry got=%h want=%h", obs(), e); end
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) req(3'b001);
      else        tick(1);
      es = (i < 4) ? 8'd2 : 8'd1;
      if (i < 8) e = {3'd5, 2'd3, es, 1'b1, 1'b0, 1'b1};
      else       e = {3'd1, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      total++; if (obs() !== e) begin bad++; $display("FAIL exit_step%0d got=%h want=%h", i, obs(), e); end
    end
  endtask

  task automatic test_clean();
    logic [15:0] e;
    req(3'b100);
    e = {3'd6, 2'd0, 8'd5, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_entry got=%h want=%h", obs(), e); end
    tick(19);
    e = {3'd6, 2'd0, 8'd1, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_c19 got=%h want=%h", obs(), e); end
    tick(1);
    e = {3'd1, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_done got=%h want=%h", obs(), e); end
    tick(1);
    e = {3'd1, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_pulse_end got=%h want=%h", obs(), e); end
    req(3'b001);
    req(3'b100);
    e = {3'd2, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_from_l1 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_power_interrupt();
    logic [15:0] e;
    req(3'b000);
    req(3'b100);
    tick(6);
    e = {3'd6, 2'd0, 8'd4, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_c6 got=%h want=%h", obs(), e); end
    hif.power_on = 1'b0;
    tick(1);
    e = {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL clean_power_drop got=%h want=%h", obs(), e); end
    hif.power_on = 1'b1;
    tick(1);
    e = {3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL repower got=%h want=%h", obs(), e); end
    req(3'b011);
    e = {3'd4, 2'd3, 8'd3, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL repower_hurr got=%h want=%h", obs(), e); end
  endtask

  task automatic test_collision();
    logic [15:0] e;
    tick(11);
    e = {3'd4, 2'd3, 8'd1, 1'b1, 1'b0, 1'b1};
    total++; if (obs() !== e) begin bad++; $display("FAIL coll_pre got=%h want=%h", obs(), e); end
    req(3'b000);
    e = {3'd3, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL coll_edge got=%h want=%h", obs(), e); end
    tick(9);
    total++; if (obs() !== e) begin bad++; $display("FAIL coll_settle got=%h want=%h", obs(), e); end
    req(3'b101);
    req(3'b111);
    total++; if (obs() !== e) begin bad++; $display("FAIL bad_mode got=%h want=%h", obs(), e); end
  endtask

  task automatic test_reset_mid_and_off();
    logic [15:0] e;
    req(3'b000);
    req(3'b100);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    e = {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL reset_mid got=%h want=%h", obs(), e); end
    tick(1);
    e = {3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL reset_mid_resume got=%h want=%h", obs(), e); end
    hif.power_on = 1'b0;
    tick(1);
    req(3'b001);
    e = {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    total++; if (obs() !== e) begin bad++; $display("FAIL req_in_off got=%h want=%h", obs(), e); end
  endtask

  initial begin
    hif.power_on  = 1'b0;
    hif.req_valid = 1'b0;
    hif.req_mode  = 3'b000;
    test_reset();
    test_hurricane_once();
    test_early_exit();
    test_clean();
    test_power_interrupt();
    test_collision();
    test_reset_mid_and_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
